// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx serializer between
// NUM_REQ byte-stream requesters; the grant is held until the last byte has left.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned WORD_LENGTH  = 8,
    parameter int unsigned HOLD_TIMEOUT = 1_000_000,
    localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]             i_req_last,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_tx_start,
    output logic [WORD_LENGTH-1:0]         o_tx_data,
    input  logic                           i_tx_ready,
    output logic                           o_grant_valid,
    output logic [ID_W-1:0]                o_grant_id,
    output logic                           o_pkt_done
);

    localparam int unsigned CNT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_START,
        S_DONE
    } state_t;

    state_t                 r_state,        w_state_next;
    logic [ID_W-1:0]        r_rr_ptr,       w_rr_ptr_next;
    logic [ID_W-1:0]        r_grant_id,     w_grant_id_next;
    logic                   r_grant_valid,  w_grant_valid_next;
    logic                   r_tx_start,     w_tx_start_next;
    logic [WORD_LENGTH-1:0] r_tx_data,      w_tx_data_next;
    logic                   r_pkt_done,     w_pkt_done_next;
    logic                   r_last_flag,    w_last_flag_next;
    logic [CNT_W-1:0]       r_timeout_cnt,  w_timeout_cnt_next;

    logic                   w_found_hi;
    logic                   w_found_lo;
    logic [ID_W-1:0]        w_win_hi;
    logic [ID_W-1:0]        w_win_lo;
    logic                   w_any_req;
    logic [ID_W-1:0]        w_winner;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [WORD_LENGTH-1:0] w_sel_data;
    logic                   w_transfer;
    logic                   w_timeout_hit;
    logic [ID_W-1:0]        w_next_ptr;

    // Round-robin pick: lowest valid index at or above rr_ptr, else wrap to
    // the lowest valid index overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[i] && !w_found_hi && (ID_W'(i) >= r_rr_ptr)) begin
                w_found_hi = 1'b1;
                w_win_hi   = ID_W'(i);
            end
            if (i_req_valid[i] && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_win_lo   = ID_W'(i);
            end
        end
        w_any_req = w_found_lo;
        w_winner  = w_found_hi ? w_win_hi : w_win_lo;
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        o_req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_sel_valid    = i_req_valid[i];
                w_sel_last     = i_req_last[i];
                w_sel_data     = i_req_data[i*WORD_LENGTH +: WORD_LENGTH];
                o_req_ready[i] = (r_state == S_SEND) && i_req_valid[i] && i_tx_ready;
            end
        end
    end

    assign w_transfer    = (r_state == S_SEND) && w_sel_valid && i_tx_ready;
    assign w_timeout_hit = (HOLD_TIMEOUT != 0) &&
                           ((32'(r_timeout_cnt) + 32'd1) == HOLD_TIMEOUT);
    assign w_next_ptr    = (32'(r_grant_id) == (NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    always_comb begin
        w_state_next       = r_state;
        w_rr_ptr_next      = r_rr_ptr;
        w_grant_id_next    = r_grant_id;
        w_grant_valid_next = r_grant_valid;
        w_tx_start_next    = r_tx_start;
        w_tx_data_next     = r_tx_data;
        w_pkt_done_next    = 1'b0;
        w_last_flag_next   = r_last_flag;
        w_timeout_cnt_next = r_timeout_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant_valid_next = 1'b1;
                    w_grant_id_next    = w_winner;
                    w_timeout_cnt_next = '0;
                    w_state_next       = S_SEND;
                end
            end
            S_SEND: begin
                if (w_transfer) begin
                    w_tx_data_next     = w_sel_data;
                    w_last_flag_next   = w_sel_last;
                    w_tx_start_next    = 1'b1;
                    w_timeout_cnt_next = '0;
                    w_state_next       = S_START;
                end else if (w_timeout_hit) begin
                    // Stalled owner: release like a last byte, but no pkt_done.
                    w_grant_valid_next = 1'b0;
                    w_rr_ptr_next      = w_next_ptr;
                    w_timeout_cnt_next = '0;
                    w_state_next       = S_IDLE;
                end else if (HOLD_TIMEOUT != 0) begin
                    w_timeout_cnt_next = r_timeout_cnt + CNT_W'(1);
                end
            end
            S_START: begin
                // uart_tx only takes the byte on a baud tick; busy marks acceptance.
                if (!i_tx_ready) begin
                    w_tx_start_next = 1'b0;
                    w_state_next    = S_DONE;
                end
            end
            S_DONE: begin
                if (i_tx_ready) begin
                    if (r_last_flag) begin
                        w_pkt_done_next    = 1'b1;
                        w_grant_valid_next = 1'b0;
                        w_rr_ptr_next      = w_next_ptr;
                        w_state_next       = S_IDLE;
                    end else begin
                        w_state_next = S_SEND;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_pkt_done    <= 1'b0;
            r_last_flag   <= 1'b0;
            r_timeout_cnt <= '0;
        end else begin
            r_state       <= w_state_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_grant_id    <= w_grant_id_next;
            r_grant_valid <= w_grant_valid_next;
            r_tx_start    <= w_tx_start_next;
            r_tx_data     <= w_tx_data_next;
            r_pkt_done    <= w_pkt_done_next;
            r_last_flag   <= w_last_flag_next;
            r_timeout_cnt <= w_timeout_cnt_next;
        end
    end

    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_id    = r_grant_id;
    assign o_pkt_done    = r_pkt_done;

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(o_req_ready));
    a_start_owned: assert property (@(posedge clk) disable iff (reset)
        o_tx_start |-> o_grant_valid);
    a_data_stable: assert property (@(posedge clk) disable iff (reset)
        (o_tx_start && $past(o_tx_start)) |-> $stable(o_tx_data));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table for a single packet, then
// scripted multi-requester sequences against a small uart_tx model.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned WL   = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  i_req_valid;
    logic [NREQ*WL-1:0] i_req_data;
    logic [NREQ-1:0]  i_req_last;
    logic [NREQ-1:0]  o_req_ready;
    logic             o_tx_start;
    logic [WL-1:0]    o_tx_data;
    logic             i_tx_ready;
    logic             o_grant_valid;
    logic [1:0]       o_grant_id;
    logic             o_pkt_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .WORD_LENGTH  (WL),
        .HOLD_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req_valid   (i_req_valid),
        .i_req_data    (i_req_data),
        .i_req_last    (i_req_last),
        .o_req_ready   (o_req_ready),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .i_tx_ready    (i_tx_ready),
        .o_grant_valid (o_grant_valid),
        .o_grant_id    (o_grant_id),
        .o_pkt_done    (o_pkt_done)
    );

    typedef struct {
        logic [3:0] valid;
        logic [7:0] data0;
        logic [3:0] last;
        logic       txr;
        logic [3:0] rdy;
        logic       ts;
        logic [7:0] td;
        logic       gv;
        logic [1:0] gid;
        logic       pd;
    } vec_t;

    vec_t tbl [15];

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] rq [4][$];
    logic [3:0] hs;
    logic [3:0] en;
    logic       gv_prev;
    int         grant_log [$];
    logic [7:0] tx_log [$];
    int         pd_cnt, r0_early, unstable;
    int         busy_cnt, acc_cnt, accept_delay, busy_len, acc_seen;
    logic [7:0] acc_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {o_req_ready, o_tx_start, o_tx_data, o_grant_valid, o_grant_id, o_pkt_done};
    endfunction

    task automatic set_row(input int r, input logic [3:0] v, input logic [7:0] d0,
                           input logic [3:0] l, input logic txr, input logic [3:0] rdy,
                           input logic ts, input logic [7:0] td, input logic gv,
                           input logic [1:0] gid, input logic pd);
        tbl[r].valid = v;   tbl[r].data0 = d0; tbl[r].last = l;  tbl[r].txr = txr;
        tbl[r].rdy   = rdy; tbl[r].ts    = ts; tbl[r].td   = td; tbl[r].gv  = gv;
        tbl[r].gid   = gid; tbl[r].pd    = pd;
    endtask

    task automatic clear_bench();
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        i_tx_ready  = 1'b1;
        for (int i = 0; i < 4; i++) rq[i].delete();
        hs = '0; en = '1; gv_prev = 1'b0;
        grant_log.delete(); tx_log.delete();
        pd_cnt = 0; r0_early = 0; unstable = 0;
        busy_cnt = 0; acc_cnt = 0; accept_delay = 0; busy_len = 3; acc_seen = 0;
        acc_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_bench();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: advance the uart_tx model, retire accepted bytes, drive
    // requesters, then sample outputs well before the next rising edge.
    task automatic step();
        @(negedge clk);
        if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) i_tx_ready = 1'b1;
        end else if (i_tx_ready) begin
            if (acc_cnt != 0 && (!o_tx_start || o_tx_data !== acc_data)) unstable++;
            if (o_tx_start) begin
                if (acc_cnt == 0) acc_data = o_tx_data;
                if (acc_cnt >= accept_delay) begin
                    i_tx_ready = 1'b0;
                    tx_log.push_back(o_tx_data);
                    acc_seen = acc_cnt;
                    busy_cnt = busy_len;
                    acc_cnt  = 0;
                end else begin
                    acc_cnt++;
                end
            end else begin
                acc_cnt = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) void'(rq[i].pop_front());
            if (en[i] && rq[i].size() != 0) begin
                i_req_valid[i]       = 1'b1;
                i_req_data[i*8 +: 8] = rq[i][0][7:0];
                i_req_last[i]        = rq[i][0][8];
            end else begin
                i_req_valid[i] = 1'b0;
                i_req_last[i]  = 1'b0;
            end
        end
        #1;
        hs = i_req_valid & o_req_ready;
        if (o_grant_valid && !gv_prev) grant_log.push_back(int'(o_grant_id));
        gv_prev = o_grant_valid;
        if (o_pkt_done) pd_cnt++;
        if (o_req_ready[0] && pd_cnt == 0) r0_early++;
    endtask

    function automatic logic is_quiet();
        logic q;
        q = !o_grant_valid && !o_tx_start && i_tx_ready && (busy_cnt == 0);
        for (int i = 0; i < 4; i++) if (rq[i].size() != 0) q = 1'b0;
        return q;
    endfunction

    task automatic run_until_quiet(input string name, input int max);
        int   n;
        logic q;
        n = 0;
        do begin
            step();
            n++;
            q = is_quiet();
        end while (!q && n < max);
        check({name, "_quiet"}, 64'(q), 64'd1);
    endtask

    task automatic pack_glog(output logic [63:0] p);
        p = '0;
        foreach (grant_log[k]) p = {p[59:0], 4'(grant_log[k])};
    endtask

    task automatic pack_txlog(output logic [63:0] p);
        p = '0;
        foreach (tx_log[k]) p = {p[55:0], tx_log[k]};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] p;
        int          n;

        //        valid    d0     last     txr   rdy      ts    td     gv    gid   pd
        set_row(0,  4'b0001, 8'hA5, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        set_row(1,  4'b0001, 8'hA5, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
        set_row(2,  4'b0001, 8'h5A, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA5, 1'b1, 2'd0, 1'b0);
        set_row(3,  4'b0001, 8'h5A, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 1'b1, 2'd0, 1'b0);
        set_row(4,  4'b0001, 8'h5A, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd0, 1'b0);
        set_row(5,  4'b0001, 8'h5A, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd0, 1'b0);
        set_row(6,  4'b0001, 8'h5A, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'hA5, 1'b1, 2'd0, 1'b0);
        set_row(7,  4'b0001, 8'hFF, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h5A, 1'b1, 2'd0, 1'b0);
        set_row(8,  4'b0001, 8'hFF, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'h5A, 1'b1, 2'd0, 1'b0);
        set_row(9,  4'b0001, 8'hFF, 4'b0001, 1'b1, 4'b0001, 1'b0, 8'h5A, 1'b1, 2'd0, 1'b0);
        set_row(10, 4'b0000, 8'h00, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hFF, 1'b1, 2'd0, 1'b0);
        set_row(11, 4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hFF, 1'b1, 2'd0, 1'b0);
        set_row(12, 4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hFF, 1'b0, 2'd0, 1'b1);
        set_row(13, 4'b0011, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hFF, 1'b0, 2'd0, 1'b0);
        set_row(14, 4'b0011, 8'h00, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'hFF, 1'b1, 2'd1, 1'b0);

        reset = 1'b1;
        clear_bench();
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 64'(outs()), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single requester, three bytes, cycle by cycle; rows 13-14 show rr_ptr=1.
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            i_req_valid = tbl[r].valid;
            i_req_data  = {24'h0, tbl[r].data0};
            i_req_last  = tbl[r].last;
            i_tx_ready  = tbl[r].txr;
            #1;
            n_vec++;
            if (outs() !== {tbl[r].rdy, tbl[r].ts, tbl[r].td, tbl[r].gv, tbl[r].gid, tbl[r].pd}) begin
                n_err++;
                $display("FAIL t1_row%0d: rdy=%b ts=%b td=%h gv=%b gid=%0d pd=%b, expected rdy=%b ts=%b td=%h gv=%b gid=%0d pd=%b",
                         r, o_req_ready, o_tx_start, o_tx_data, o_grant_valid, o_grant_id, o_pkt_done,
                         tbl[r].rdy, tbl[r].ts, tbl[r].td, tbl[r].gv, tbl[r].gid, tbl[r].pd);
            end
        end

        // All four at once, then 1 and 3 again.
        do_reset();
        for (int i = 0; i < 4; i++) rq[i].push_back(9'h110 + 9'(i));
        run_until_quiet("t2a", 200);
        pack_glog(p);   check("t2a_grant_order", p, 64'h0123);
        check("t2a_grant_count", 64'(grant_log.size()), 64'd4);
        pack_txlog(p);  check("t2a_bytes", p, 64'h10111213);
        check("t2a_pkt_done", 64'(pd_cnt), 64'd4);
        grant_log.delete(); tx_log.delete(); pd_cnt = 0;
        rq[1].push_back(9'h121);
        rq[3].push_back(9'h123);
        run_until_quiet("t2b", 100);
        pack_glog(p);   check("t2b_grant_order", p, 64'h13);
        check("t2b_grant_count", 64'(grant_log.size()), 64'd2);
        pack_txlog(p);  check("t2b_bytes", p, 64'h2123);

        // Packet hold: req 0 waits behind req 2's 4-byte packet.
        do_reset();
        en = 4'b0100;
        rq[2].push_back(9'h0C0); rq[2].push_back(9'h0C1);
        rq[2].push_back(9'h0C2); rq[2].push_back(9'h1C3);
        rq[0].push_back(9'h10A);
        n = 0;
        while (!o_grant_valid && n < 10) begin step(); n++; end
        check("t3_first_grant", 64'({o_grant_valid, o_grant_id}), 64'b110);
        en = 4'b1111;
        run_until_quiet("t3", 200);
        pack_glog(p);   check("t3_grant_order", p, 64'h20);
        pack_txlog(p);  check("t3_bytes", p, 64'hC0C1C2C30A);
        check("t3_ready0_early", 64'(r0_early), 64'd0);
        check("t3_pkt_done", 64'(pd_cnt), 64'd2);

        // Stall: one non-last byte, then valid drops; timeout after 16 SEND cycles.
        do_reset();
        rq[1].push_back(9'h0B1);
        n = 0;
        while (tx_log.size() == 0 && n < 50) begin step(); n++; end
        check("t4_byte_sent", 64'(tx_log.size()), 64'd1);
        n = 0;
        while (!i_tx_ready && n < 50) begin step(); n++; end
        n = 0;
        step();
        while (o_grant_valid && n < 100) begin n++; step(); end
        check("t4_send_cycles", 64'(n), 64'd16);
        check("t4_no_pkt_done", 64'(pd_cnt), 64'd0);
        rq[0].push_back(9'h10A);
        rq[2].push_back(9'h10C);
        run_until_quiet("t4", 100);
        pack_glog(p);   check("t4_grant_order", p, 64'h120);

        // Slow uart_tx: accept only after 100 ready-high cycles.
        do_reset();
        accept_delay = 100;
        rq[3].push_back(9'h13C);
        run_until_quiet("t5", 400);
        check("t5_unstable", 64'(unstable), 64'd0);
        check("t5_hold_cycles", 64'(acc_seen), 64'd100);
        check("t5_byte_count", 64'(tx_log.size()), 64'd1);
        pack_txlog(p);  check("t5_byte", p, 64'h3C);
        check("t5_pkt_done", 64'(pd_cnt), 64'd1);

        // Reset while in START, then arbitration restarts from index 0.
        do_reset();
        rq[2].push_back(9'h122);
        run_until_quiet("t6a", 100);
        accept_delay = 20;
        rq[3].push_back(9'h133);
        n = 0;
        while (!o_tx_start && n < 20) begin step(); n++; end
        repeat (3) step();
        check("t6_in_start", 64'({o_tx_start, o_grant_id}), 64'b111);
        reset = 1'b1;
        #1;
        check("t6_async_reset", 64'(outs()), 64'd0);
        clear_bench();
        @(negedge clk);
        reset = 1'b0;
        rq[0].push_back(9'h144);
        rq[3].push_back(9'h155);
        run_until_quiet("t6b", 100);
        pack_glog(p);   check("t6_grant_order", p, 64'h03);
        pack_txlog(p);  check("t6_bytes", p, 64'h4455);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
